// File: rtl/npu_pkg.sv
// ============================================================================
// Module   : npu_pkg
// Brief    : Shared sizes, types and FSM encoding for the MV write-back path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package npu_pkg;

    localparam int IDATAW      = 8;
    localparam int LANES       = 4;
    localparam int BATCH       = 2;
    localparam int ACCUM_DATAW = 32;
    localparam int NUM_ATOMS   = 4;
    localparam int MV_RF_DEPTH = 512;

    localparam int MV_RF_ADDRW = $clog2(MV_RF_DEPTH);
    localparam int ATOM_IDW    = (NUM_ATOMS > 1) ? $clog2(NUM_ATOMS) : 1;
    localparam int CNTW        = 16;
    localparam int SHIFTW      = $clog2(ACCUM_DATAW);
    localparam int LANE_IDW    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int BEATW       = (BATCH > 1) ? $clog2(BATCH) : 1;

    localparam int SAT_MAX = (2 ** (IDATAW - 1)) - 1;
    localparam int SAT_MIN = -(2 ** (IDATAW - 1));

    typedef logic [BATCH-1:0][ACCUM_DATAW-1:0] accum_row_t;
    typedef logic [LANES-1:0][IDATAW-1:0]      rf_vec_t;

    typedef enum logic [1:0] {
        WB_IDLE  = 2'd0,
        WB_FILL  = 2'd1,
        WB_DRAIN = 2'd2,
        WB_DONE  = 2'd3
    } wb_state_t;

endpackage

`default_nettype wire

// File: rtl/requant_unit.sv
// ============================================================================
// Module   : requant_unit
// Brief    : One-element round / arithmetic shift / saturate to IDATAW.
//            Optional ReLU clamp when MV_WRITEBACK_RELU_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module requant_unit
    import npu_pkg::*;
(
    input  logic [ACCUM_DATAW-1:0] x_i,
    input  logic [SHIFTW-1:0]      shift_i,
    output logic [IDATAW-1:0]      y_o
);

    localparam logic signed [ACCUM_DATAW:0] c_sat_max = (ACCUM_DATAW + 1)'(SAT_MAX);
    localparam logic signed [ACCUM_DATAW:0] c_sat_min = (ACCUM_DATAW + 1)'(SAT_MIN);

    logic signed [ACCUM_DATAW:0] w_x_ext;
    logic signed [ACCUM_DATAW:0] w_round;
    logic signed [ACCUM_DATAW:0] w_sum;
    logic signed [ACCUM_DATAW:0] w_shifted;
    logic        [IDATAW-1:0]    w_sat;

    // One guard bit keeps x + round from overflowing before the shift.
    always_comb begin
        w_x_ext = {x_i[ACCUM_DATAW-1], x_i};
        w_round = '0;
        if (shift_i != '0) begin
            w_round = (ACCUM_DATAW + 1)'(1) << (shift_i - SHIFTW'(1));
        end
        w_sum     = w_x_ext + w_round;
        w_shifted = w_sum >>> shift_i;

        if (w_shifted > c_sat_max) begin
            w_sat = c_sat_max[IDATAW-1:0];
        end else if (w_shifted < c_sat_min) begin
            w_sat = c_sat_min[IDATAW-1:0];
        end else begin
            w_sat = w_shifted[IDATAW-1:0];
        end

`ifdef MV_WRITEBACK_RELU_EN
        y_o = w_sat[IDATAW-1] ? '0 : w_sat;
`else
        y_o = w_sat;
`endif
    end

endmodule

`default_nettype wire

// File: rtl/mv_writeback.sv
// ============================================================================
// Module   : mv_writeback
// Brief    : Drains accumulator rows, requantizes, packs LANES rows per batch
//            item and writes the vectors back into the slice MV register file.
//            Build option: MV_WRITEBACK_RELU_EN (ReLU after saturation).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mv_writeback
    import npu_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_cmd_valid,
    output logic                   o_cmd_ready,
    input  logic [MV_RF_ADDRW-1:0] i_cmd_base,
    input  logic [ATOM_IDW-1:0]    i_cmd_wid,
    input  logic [CNTW-1:0]        i_cmd_rows,
    input  logic [SHIFTW-1:0]      i_cmd_shift,
    input  accum_row_t             i_ofifo_data,
    input  logic                   i_ofifo_ready,
    output logic                   o_ofifo_ren,
    output logic [MV_RF_ADDRW-1:0] o_waddr,
    output logic [ATOM_IDW-1:0]    o_wid,
    output rf_vec_t                o_wdata,
    output logic                   o_wvalid,
    output logic                   o_busy,
    output logic                   o_done
);

    localparam logic [LANE_IDW-1:0] c_last_lane = LANE_IDW'(LANES - 1);
    localparam logic [BEATW-1:0]    c_last_beat = BEATW'(BATCH - 1);

    wb_state_t              state_q, state_d;
    logic [MV_RF_ADDRW-1:0] grp_addr_q, grp_addr_d;
    logic [ATOM_IDW-1:0]    wid_q, wid_d;
    logic [CNTW-1:0]        rows_q, rows_d;
    logic [CNTW-1:0]        rows_done_q, rows_done_d;
    logic [SHIFTW-1:0]      shift_q, shift_d;
    logic [LANE_IDW-1:0]    lane_q, lane_d;
    logic [BEATW-1:0]       beat_q, beat_d;
    rf_vec_t                buf_q [BATCH];
    rf_vec_t                buf_d [BATCH];
    logic [MV_RF_ADDRW-1:0] waddr_q, waddr_d;
    logic [ATOM_IDW-1:0]    wid_out_q, wid_out_d;
    rf_vec_t                wdata_q, wdata_d;
    logic                   wvalid_q, wvalid_d;
    logic                   done_q, done_d;

    logic [BATCH-1:0][IDATAW-1:0] w_rq;

    for (genvar b = 0; b < BATCH; b++) begin : g_requant
        requant_unit u_requant (
            .x_i     (i_ofifo_data[b]),
            .shift_i (shift_q),
            .y_o     (w_rq[b])
        );
    end

    always_comb begin
        state_d     = state_q;
        grp_addr_d  = grp_addr_q;
        wid_d       = wid_q;
        rows_d      = rows_q;
        rows_done_d = rows_done_q;
        shift_d     = shift_q;
        lane_d      = lane_q;
        beat_d      = beat_q;
        buf_d       = buf_q;
        waddr_d     = waddr_q;
        wid_out_d   = wid_out_q;
        wdata_d     = wdata_q;
        wvalid_d    = 1'b0;
        done_d      = 1'b0;
        o_ofifo_ren = 1'b0;

        case (state_q)
            WB_IDLE: begin
                if (i_cmd_valid) begin
                    grp_addr_d  = i_cmd_base;
                    wid_d       = i_cmd_wid;
                    rows_d      = i_cmd_rows;
                    shift_d     = i_cmd_shift;
                    rows_done_d = '0;
                    lane_d      = '0;
                    beat_d      = '0;
                    for (int b = 0; b < BATCH; b++) buf_d[b] = '0;
                    state_d = (i_cmd_rows == '0) ? WB_DONE : WB_FILL;
                end
            end
            WB_FILL: begin
                o_ofifo_ren = i_ofifo_ready;
                if (i_ofifo_ready) begin
                    for (int b = 0; b < BATCH; b++) buf_d[b][lane_q] = w_rq[b];
                    lane_d      = lane_q + LANE_IDW'(1);
                    rows_done_d = rows_done_q + CNTW'(1);
                    if (lane_q == c_last_lane || rows_done_d == rows_q) begin
                        beat_d  = '0;
                        state_d = WB_DRAIN;
                    end
                end
            end
            WB_DRAIN: begin
                // Address wrap relies on MV_RF_DEPTH being a power of two.
                wvalid_d  = 1'b1;
                wdata_d   = buf_q[beat_q];
                waddr_d   = grp_addr_q + MV_RF_ADDRW'(beat_q);
                wid_out_d = wid_q;
                beat_d    = beat_q + BEATW'(1);
                if (beat_q == c_last_beat) begin
                    for (int b = 0; b < BATCH; b++) buf_d[b] = '0;
                    grp_addr_d = grp_addr_q + MV_RF_ADDRW'(BATCH);
                    lane_d     = '0;
                    state_d    = (rows_done_q == rows_q) ? WB_DONE : WB_FILL;
                end
            end
            WB_DONE: begin
                done_d  = 1'b1;
                state_d = WB_IDLE;
            end
            default: state_d = WB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= WB_IDLE;
            grp_addr_q  <= '0;
            wid_q       <= '0;
            rows_q      <= '0;
            rows_done_q <= '0;
            shift_q     <= '0;
            lane_q      <= '0;
            beat_q      <= '0;
            for (int b = 0; b < BATCH; b++) buf_q[b] <= '0;
            waddr_q     <= '0;
            wid_out_q   <= '0;
            wdata_q     <= '0;
            wvalid_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            grp_addr_q  <= grp_addr_d;
            wid_q       <= wid_d;
            rows_q      <= rows_d;
            rows_done_q <= rows_done_d;
            shift_q     <= shift_d;
            lane_q      <= lane_d;
            beat_q      <= beat_d;
            for (int b = 0; b < BATCH; b++) buf_q[b] <= buf_d[b];
            waddr_q     <= waddr_d;
            wid_out_q   <= wid_out_d;
            wdata_q     <= wdata_d;
            wvalid_q    <= wvalid_d;
            done_q      <= done_d;
        end
    end

    assign o_cmd_ready = (state_q == WB_IDLE);
    assign o_busy      = (state_q != WB_IDLE);
    assign o_waddr     = waddr_q;
    assign o_wid       = wid_out_q;
    assign o_wdata     = wdata_q;
    assign o_wvalid    = wvalid_q;
    assign o_done      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_mv_writeback.sv
// ============================================================================
// Module   : tb_mv_writeback
// Brief    : Directed self-checking bench for mv_writeback with a write
//            scoreboard built from a plain-arithmetic requant/pack model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mv_writeback;
    import npu_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   i_cmd_valid;
    logic                   o_cmd_ready;
    logic [MV_RF_ADDRW-1:0] i_cmd_base;
    logic [ATOM_IDW-1:0]    i_cmd_wid;
    logic [CNTW-1:0]        i_cmd_rows;
    logic [SHIFTW-1:0]      i_cmd_shift;
    accum_row_t             i_ofifo_data;
    logic                   i_ofifo_ready;
    logic                   o_ofifo_ren;
    logic [MV_RF_ADDRW-1:0] o_waddr;
    logic [ATOM_IDW-1:0]    o_wid;
    rf_vec_t                o_wdata;
    logic                   o_wvalid;
    logic                   o_busy;
    logic                   o_done;

    mv_writeback dut (
        .clk           (clk),
        .rst           (rst),
        .i_cmd_valid   (i_cmd_valid),
        .o_cmd_ready   (o_cmd_ready),
        .i_cmd_base    (i_cmd_base),
        .i_cmd_wid     (i_cmd_wid),
        .i_cmd_rows    (i_cmd_rows),
        .i_cmd_shift   (i_cmd_shift),
        .i_ofifo_data  (i_ofifo_data),
        .i_ofifo_ready (i_ofifo_ready),
        .o_ofifo_ren   (o_ofifo_ren),
        .o_waddr       (o_waddr),
        .o_wid         (o_wid),
        .o_wdata       (o_wdata),
        .o_wvalid      (o_wvalid),
        .o_busy        (o_busy),
        .o_done        (o_done)
    );

    always #5 clk = ~clk;

    typedef longint row_t [BATCH];
    typedef struct {
        int      addr;
        int      wid;
        rf_vec_t data;
    } wr_t;

    row_t       cmd_rows [$];
    accum_row_t fifo_q   [$];
    wr_t        exp_q    [$];
    wr_t        obs_q    [$];
    logic       stall;
    int         n_checks = 0;
    int         n_pass   = 0;
    int         done_seen = 0;
    int         wr_seen   = 0;
    wr_t        cmp_o, cmp_e;

    task automatic chk(input string name, input bit ok, input longint act, input longint exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Reference requantizer in 64-bit arithmetic.
    function automatic int rq(input longint x, input int sh);
        longint r, y;
        r = (sh > 0) ? (longint'(1) << (sh - 1)) : 0;
        y = (x + r) >>> sh;
        if (y > SAT_MAX) y = SAT_MAX;
        if (y < SAT_MIN) y = SAT_MIN;
`ifdef MV_WRITEBACK_RELU_EN
        if (y < 0) y = 0;
`endif
        return int'(y);
    endfunction

    function automatic rf_vec_t pack4(input int a, input int b, input int c, input int d);
        rf_vec_t v;
        v[0] = IDATAW'(a);
        v[1] = IDATAW'(b);
        v[2] = IDATAW'(c);
        v[3] = IDATAW'(d);
        return v;
    endfunction

    function automatic void add_row(input longint a, input longint b);
        row_t r;
        r[0] = a;
        r[1] = b;
        cmd_rows.push_back(r);
    endfunction

    function automatic void build_exp(input int base, input int wid, input int sh);
        int n    = cmd_rows.size();
        int ngrp = (n + LANES - 1) / LANES;
        for (int g = 0; g < ngrp; g++) begin
            for (int b = 0; b < BATCH; b++) begin
                wr_t e;
                e.addr = (base + g * BATCH + b) % MV_RF_DEPTH;
                e.wid  = wid;
                e.data = '0;
                for (int l = 0; l < LANES; l++)
                    if (g * LANES + l < n) e.data[l] = IDATAW'(rq(cmd_rows[g * LANES + l][b], sh));
                exp_q.push_back(e);
            end
        end
    endfunction

    task automatic drive_fifo();
        i_ofifo_ready = (fifo_q.size() > 0) && !stall;
        i_ofifo_data  = (fifo_q.size() > 0) ? fifo_q[0] : '0;
    endtask

    task automatic push_rows();
        foreach (cmd_rows[i]) begin
            accum_row_t r;
            for (int b = 0; b < BATCH; b++) r[b] = ACCUM_DATAW'(cmd_rows[i][b]);
            fifo_q.push_back(r);
        end
        drive_fifo();
    endtask

    // Advance one clock; the FIFO pops whatever the DUT asked for at the edge.
    task automatic tick();
        logic pop;
        @(negedge clk);
        pop = o_ofifo_ren && i_ofifo_ready;
        @(posedge clk);
        #1;
        if (pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
        drive_fifo();
    endtask

    task automatic issue(input int base, input int wid, input int rows, input int sh);
        i_cmd_base  = MV_RF_ADDRW'(base);
        i_cmd_wid   = ATOM_IDW'(wid);
        i_cmd_rows  = CNTW'(rows);
        i_cmd_shift = SHIFTW'(sh);
        i_cmd_valid = 1'b1;
        tick();
        i_cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input int start_done);
        int k = 0;
        while (done_seen == start_done && k < 300) begin
            tick();
            k++;
        end
        chk({name, "_done"}, done_seen == start_done + 1, done_seen - start_done, 1);
        chk({name, "_drained"}, exp_q.size() == 0, exp_q.size(), 0);
    endtask

    // Scoreboard: every write beat must match the next modelled write.
    always @(negedge clk) begin
        if (o_wvalid === 1'b1) begin
            cmp_o.addr = int'(o_waddr);
            cmp_o.wid  = int'(o_wid);
            cmp_o.data = o_wdata;
            obs_q.push_back(cmp_o);
            wr_seen++;
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 1'b0, cmp_o.addr, -1);
            end else begin
                cmp_e = exp_q.pop_front();
                chk("wr_addr", cmp_o.addr == cmp_e.addr, cmp_o.addr, cmp_e.addr);
                chk("wr_wid", cmp_o.wid == cmp_e.wid, cmp_o.wid, cmp_e.wid);
                chk("wr_data", cmp_o.data === cmp_e.data, longint'(cmp_o.data), longint'(cmp_e.data));
            end
        end
        if (o_done === 1'b1) done_seen++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int d0, w0, k;
        rst = 1'b1;
        stall = 1'b0;
        i_cmd_valid = 1'b0;
        i_cmd_base = '0;
        i_cmd_wid = '0;
        i_cmd_rows = '0;
        i_cmd_shift = '0;
        drive_fifo();
        repeat (3) tick();

        chk("rst_cmd_ready", o_cmd_ready === 1'b1, o_cmd_ready, 1);
        chk("rst_busy", o_busy === 1'b0, o_busy, 0);
        chk("rst_wvalid", o_wvalid === 1'b0, o_wvalid, 0);
        chk("rst_done", o_done === 1'b0, o_done, 0);
        chk("rst_ren", o_ofifo_ren === 1'b0, o_ofifo_ren, 0);
        rst = 1'b0;
        tick();

        // Pin the reference model to hand-worked values.
`ifdef MV_WRITEBACK_RELU_EN
        chk("model_rq_pos", rq(24, 4) == 2, rq(24, 4), 2);
        chk("model_rq_neg", rq(-24, 4) == 0, rq(-24, 4), 0);
        chk("model_rq_sat_hi", rq(5000, 4) == 127, rq(5000, 4), 127);
        chk("model_rq_sat_lo", rq(-5000, 4) == 0, rq(-5000, 4), 0);
`else
        chk("model_rq_pos", rq(24, 4) == 2, rq(24, 4), 2);
        chk("model_rq_neg", rq(-24, 4) == -1, rq(-24, 4), -1);
        chk("model_rq_sat_hi", rq(5000, 4) == 127, rq(5000, 4), 127);
        chk("model_rq_sat_lo", rq(-5000, 4) == -128, rq(-5000, 4), -128);
`endif

        // Full group, shift 0.
        cmd_rows.delete(); obs_q.delete();
        add_row(1, -1); add_row(2, -2); add_row(3, -3); add_row(4, -4);
        push_rows(); build_exp(10, 1, 0);
        d0 = done_seen;
        issue(10, 1, 4, 0);
        wait_done("full", d0);
        chk("full_nwr", obs_q.size() == 2, obs_q.size(), 2);
        if (obs_q.size() == 2) begin
            chk("full_addr0", obs_q[0].addr == 10, obs_q[0].addr, 10);
            chk("full_addr1", obs_q[1].addr == 11, obs_q[1].addr, 11);
            chk("full_data0", obs_q[0].data === pack4(1, 2, 3, 4), longint'(obs_q[0].data), longint'(pack4(1, 2, 3, 4)));
`ifdef MV_WRITEBACK_RELU_EN
            chk("full_data1", obs_q[1].data === pack4(0, 0, 0, 0), longint'(obs_q[1].data), 0);
`else
            chk("full_data1", obs_q[1].data === pack4(-1, -2, -3, -4), longint'(obs_q[1].data), longint'(pack4(-1, -2, -3, -4)));
`endif
        end

        // Rounding and saturation, shift 4.
        cmd_rows.delete(); obs_q.delete();
        add_row(24, 5000); add_row(-24, -5000); add_row(5000, 24); add_row(-5000, -24);
        push_rows(); build_exp(100, 2, 4);
        d0 = done_seen;
        issue(100, 2, 4, 4);
        wait_done("round", d0);
        if (obs_q.size() > 0) begin
`ifdef MV_WRITEBACK_RELU_EN
            chk("round_lit", obs_q[0].data === pack4(2, 0, 127, 0), longint'(obs_q[0].data), longint'(pack4(2, 0, 127, 0)));
`else
            chk("round_lit", obs_q[0].data === pack4(2, -1, 127, -128), longint'(obs_q[0].data), longint'(pack4(2, -1, 127, -128)));
`endif
        end else begin
            chk("round_lit_present", 1'b0, 0, 1);
        end

        // Partial second group with address wrap.
        cmd_rows.delete(); obs_q.delete();
        for (int i = 1; i <= 6; i++) add_row(100 * i, -37 * i);
        push_rows(); build_exp(510, 3, 1);
        d0 = done_seen;
        issue(510, 3, 6, 1);
        wait_done("wrap", d0);
        chk("wrap_nwr", obs_q.size() == 4, obs_q.size(), 4);
        if (obs_q.size() == 4) begin
            chk("wrap_addr1", obs_q[1].addr == 511, obs_q[1].addr, 511);
            chk("wrap_addr2", obs_q[2].addr == 0, obs_q[2].addr, 0);
            chk("wrap_addr3", obs_q[3].addr == 1, obs_q[3].addr, 1);
            chk("wrap_pad", obs_q[2].data[2] == '0 && obs_q[2].data[3] == '0 &&
                obs_q[3].data[2] == '0 && obs_q[3].data[3] == '0, longint'(obs_q[2].data), 0);
        end

        // FIFO stall mid-FILL.
        cmd_rows.delete(); obs_q.delete();
        add_row(7, 70); add_row(-9, 90); add_row(300, -300); add_row(15, -15);
        push_rows(); build_exp(20, 0, 2);
        d0 = done_seen;
        w0 = wr_seen;
        issue(20, 0, 4, 2);
        tick(); tick();
        stall = 1'b1;
        drive_fifo();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_hold", o_ofifo_ren === 1'b0 && o_wvalid === 1'b0 && o_busy === 1'b1,
                {o_ofifo_ren, o_wvalid, o_busy}, 3'b001);
        end
        chk("stall_fifo_left", fifo_q.size() == 2, fifo_q.size(), 2);
        chk("stall_no_wr", wr_seen == w0, wr_seen - w0, 0);
        stall = 1'b0;
        drive_fifo();
        wait_done("stall", d0);

        // Reset in the middle of DRAIN.
        cmd_rows.delete(); obs_q.delete();
        add_row(1, 2); add_row(3, 4); add_row(5, 6); add_row(7, 8);
        push_rows(); build_exp(40, 1, 0);
        d0 = done_seen;
        issue(40, 1, 4, 0);
        k = 0;
        while (o_wvalid !== 1'b1 && k < 50) begin
            tick();
            k++;
        end
        chk("rst_mid_beat_seen", o_wvalid === 1'b1, o_wvalid, 1);
        rst = 1'b1;
        tick();
        chk("rst_mid_wvalid", o_wvalid === 1'b0, o_wvalid, 0);
        chk("rst_mid_busy", o_busy === 1'b0, o_busy, 0);
        chk("rst_mid_ready", o_cmd_ready === 1'b1, o_cmd_ready, 1);
        chk("rst_mid_done", o_done === 1'b0, o_done, 0);
        rst = 1'b0;
        w0 = wr_seen;
        repeat (6) tick();
        chk("rst_mid_no_done", done_seen == d0, done_seen - d0, 0);
        chk("rst_mid_no_wr", wr_seen == w0, wr_seen - w0, 0);
        exp_q.delete();

        // rows = 0: done exactly two cycles after accept, FIFO untouched.
        cmd_rows.delete(); obs_q.delete();
        add_row(11, 22);
        push_rows();
        w0 = wr_seen;
        issue(0, 0, 0, 0);
        chk("zero_done_t1", o_done === 1'b0, o_done, 0);
        tick();
        chk("zero_done_t2", o_done === 1'b1, o_done, 1);
        tick();
        chk("zero_done_t3", o_done === 1'b0, o_done, 0);
        chk("zero_no_pop", fifo_q.size() == 1, fifo_q.size(), 1);
        chk("zero_no_wr", wr_seen == w0, wr_seen - w0, 0);
        fifo_q.delete();
        drive_fifo();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mv_writeback.md
Name: mv_writeback

Overview:
- Downstream consumer of one mv_slice output FIFO; one instance per slice inside the NPU top.
- Drains BATCH-wide accumulator rows and requantizes each element (round, shift, saturate) to IDATAW.
- Packs LANES consecutive rows into one LANES-wide vector per batch item.
- Writes the packed vectors back into the slice MV register file through the slice write port (waddr/wid/wdata/wvalid), closing the layer-to-layer loop without host involvement.

Parameters:
- IDATAW, `IDATAW: output element width (signed).
- LANES, `LANES: elements per RF vector, i.e. rows packed per group.
- BATCH, `BATCH: accumulator results per FIFO row.
- ACCUM_DATAW, `ACCUM_DATAW: accumulator element width (signed).
- NUM_ATOMS, `NUM_ATOMS: RF banks per slice.
- MV_RF_DEPTH, `MV_RF_DEPTH: RF words per bank.
- MV_RF_ADDRW, $clog2(MV_RF_DEPTH): RF address width.
- ATOM_IDW, $clog2(NUM_ATOMS): bank id width.
- CNTW, 16: row-count width.
- SHIFTW, $clog2(ACCUM_DATAW): shift-amount width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- i_cmd_valid  in  1  command valid.
- o_cmd_ready  out  1  command accept; high only in IDLE.
- i_cmd_base  in  MV_RF_ADDRW  first RF address.
- i_cmd_wid  in  ATOM_IDW  target bank.
- i_cmd_rows  in  CNTW  FIFO rows to drain; 0 = no-op.
- i_cmd_shift  in  SHIFTW  right-shift amount.
- i_ofifo_data  in  BATCH x ACCUM_DATAW signed  FWFT head row.
- i_ofifo_ready  in  1  FIFO non-empty.
- o_ofifo_ren  out  1  pop head row.
- o_waddr  out  MV_RF_ADDRW  RF write address.
- o_wid  out  ATOM_IDW  RF bank.
- o_wdata  out  LANES x IDATAW signed  RF write vector.
- o_wvalid  out  1  write strobe; there is no backpressure.
- o_busy  out  1  high whenever not IDLE.
- o_done  out  1  one-cycle completion pulse.

Behaviour:
- Reset:
  - All outputs 0, except o_cmd_ready = 1 once IDLE is entered.
  - Pack buffer and counters cleared.
  - Reset mid-operation aborts: no further ren or wvalid, no o_done, any FIFO rows not yet popped stay in the FIFO.
- FSM states: IDLE, FILL, DRAIN, DONE.
- IDLE:
  - Command accepted on i_cmd_valid & o_cmd_ready; base, wid, rows and shift are latched.
  - rows = 0 goes directly to DONE; otherwise go to FILL.
  - grp (group index) and lane_idx reset to 0.
- FILL:
  - o_ofifo_ren = i_ofifo_ready (combinational; the head row is consumed the same cycle).
  - On each pop, requantized element b is written to buf[b][lane_idx]; lane_idx and rows_done increment.
  - Go to DRAIN when lane_idx reaches LANES, or when rows_done reaches rows (partial group).
  - Unfilled lanes of a partial group are 0.
  - Stalls indefinitely while the FIFO is empty.
- DRAIN:
  - BATCH consecutive cycles, b = 0..BATCH-1.
  - o_wvalid = 1, o_wdata = buf[b], o_wid = latched wid.
  - o_waddr = (base + grp*BATCH + b) mod MV_RF_DEPTH; wrap-around is silent.
  - All write outputs are registered.
  - After b = BATCH-1: buf cleared, grp incremented, lane_idx = 0; go to FILL if rows remain, otherwise DONE.
- DONE: o_done = 1 for one cycle, then IDLE.
- Throughput: one full group takes LANES + BATCH cycles with no FIFO stall. FILL and DRAIN do not overlap.
- Requant per element x:
  - Rounding term r = (shift > 0) ? 1 << (shift-1) : 0.
  - y = (x + r) >>> shift, computed at ACCUM_DATAW+1 bits so the add cannot overflow.
  - Saturate to [-2^(IDATAW-1), 2^(IDATAW-1)-1].
- Commands presented while busy are held off by o_cmd_ready = 0; they are not dropped.

Optional Feature:
- Macro: MV_WRITEBACK_RELU_EN.
- Defined: after saturation, negative results are forced to 0.
- Undefined: signed saturated result is written unchanged.
- The command interface is identical in both builds.

Decomposition:
- Shared package npu_pkg holds:
  - FSM state enum wb_state_t.
  - Typedefs accum_row_t (BATCH x ACCUM_DATAW) and rf_vec_t (LANES x IDATAW).
  - Saturation bounds as constants derived from IDATAW.
- Sub-module requant_unit: one element, combinational round/shift/saturate/optional ReLU. Instantiated BATCH times in a generate loop.

Test Plan:
All scenarios use IDATAW=8, LANES=4, BATCH=2, ACCUM_DATAW=32, MV_RF_DEPTH=512.
- Full group: rows=4, base=10, wid=1, shift=0; FIFO rows {1,-1},{2,-2},{3,-3},{4,-4} -> wvalid 2 cycles: addr 10 data {1,2,3,4}; addr 11 data {-1,-2,-3,-4}; then o_done pulse.
- Rounding/saturation: shift=4; elements 24, -24, 5000, -5000 -> 2, -1, 127, -128. With RELU_EN: 2, 0, 127, 0.
- Partial group plus wrap: rows=6, base=510 -> addresses 510, 511, 0, 1; the second group has lanes 2-3 = 0.
- FIFO stall: ready low for 5 cycles mid-FILL -> ren stays low, no wvalid, state holds; resumes on ready, results unchanged.
- Reset mid-DRAIN: rst asserted after the first write beat -> next cycle wvalid=0, busy=0, cmd_ready=1, no o_done.
- rows=0 command -> o_done exactly 2 cycles after accept, no ren and no wvalid.
